// File: rtl/req_arbiter_4.sv
// req_arbiter_4: four-requester arbiter for one shared resource.
// The owner keeps the grant until it drops its request or, when MAX_HOLD is
// non-zero, until it has held the resource for MAX_HOLD consecutive cycles.
// Winner selection is fixed priority (req[3] highest) or round-robin. All
// outputs come straight from flops, so there is no combinational path from
// req to gnt.
module req_arbiter_4 #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT  = 8'(MAX_HOLD);
    localparam bit         HOLD_ACTIVE = (MAX_HOLD != 0);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] gnt_id_nxt;
    logic       gnt_valid_nxt;
    logic       timeout_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;

    // Fixed priority is round-robin with the pointer parked on requester 3.
    logic [1:0] eff_ptr;
    assign eff_ptr = ROUND_ROBIN ? ptr : 2'd3;

    // Search order is p, p-1, p-2, p-3 (mod 4). Walking the list backwards
    // lets the earliest set position overwrite the later ones.
    function automatic logic [1:0] pick_winner(input logic [3:0] cand,
                                               input logic [1:0] p);
        logic [1:0] win;
        logic [1:0] idx;
        win = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p - 2'(k);
            if (cand[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    // Next-state logic: decide whether this edge arbitrates, on which
    // candidate set, and what the grant, pointer and hold counter become.
    always_comb begin
        logic       do_arb;
        logic [3:0] cand;
        logic [1:0] win;

        state_nxt     = state;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        ptr_nxt       = ptr;
        hold_cnt_nxt  = hold_cnt;
        do_arb        = 1'b0;
        cand          = 4'b0000;
        win           = 2'd0;

        case (state)
            IDLE: begin
                if (|req) begin
                    do_arb = 1'b1;
                    cand   = req;
                end
            end
            BUSY: begin
                if (!req[gnt_id]) begin
                    // Voluntary release wins over a coinciding timeout.
                    do_arb = 1'b1;
                    cand   = req;
                end else if (HOLD_ACTIVE && (hold_cnt == HOLD_LIMIT)) begin
                    // Forced release: the current owner sits this round out.
                    do_arb      = 1'b1;
                    cand        = req & ~gnt;
                    timeout_nxt = 1'b1;
                end else if (hold_cnt < HOLD_LIMIT) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (do_arb) begin
            if (|cand) begin
                win           = pick_winner(cand, eff_ptr);
                state_nxt     = BUSY;
                gnt_nxt       = 4'b0001 << win;
                gnt_id_nxt    = win;
                gnt_valid_nxt = 1'b1;
                hold_cnt_nxt  = 8'd1;
                if (ROUND_ROBIN) begin
                    ptr_nxt = win - 2'd1;
                end
            end else begin
                state_nxt     = IDLE;
                gnt_nxt       = 4'b0000;
                gnt_id_nxt    = 2'd0;
                gnt_valid_nxt = 1'b0;
                hold_cnt_nxt  = 8'd0;
            end
        end
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 2'd0;
            hold_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_req_arbiter_4.sv
// tb_req_arbiter_4: directed bench for req_arbiter_4. Five instances with
// different parameter sets share one clock and reset; each scenario task
// drives one of them. Observed outputs are packed as
// {gnt, gnt_id, gnt_valid, timeout} and compared against hand-written values.
module tb_req_arbiter_4;

    logic clk;
    logic reset_n;

    logic [3:0] req_fix, req_rr, req_t4, req_t2, req_t3;
    logic [3:0] gnt_fix, gnt_rr, gnt_t4, gnt_t2, gnt_t3;
    logic [1:0] id_fix, id_rr, id_t4, id_t2, id_t3;
    logic       val_fix, val_rr, val_t4, val_t2, val_t3;
    logic       to_fix, to_rr, to_t4, to_t2, to_t3;

    logic [7:0] obs_fix, obs_rr, obs_t4, obs_t2, obs_t3;
    assign obs_fix = {gnt_fix, id_fix, val_fix, to_fix};
    assign obs_rr  = {gnt_rr, id_rr, val_rr, to_rr};
    assign obs_t4  = {gnt_t4, id_t4, val_t4, to_t4};
    assign obs_t2  = {gnt_t2, id_t2, val_t2, to_t2};
    assign obs_t3  = {gnt_t3, id_t3, val_t3, to_t3};

    int tests_run = 0;
    int tests_failed = 0;

    req_arbiter_4 #(.ROUND_ROBIN(1'b0), .MAX_HOLD(0)) dut_fix (
        .clk(clk), .reset_n(reset_n), .req(req_fix), .gnt(gnt_fix),
        .gnt_id(id_fix), .gnt_valid(val_fix), .timeout(to_fix));

    req_arbiter_4 #(.ROUND_ROBIN(1'b1), .MAX_HOLD(0)) dut_rr (
        .clk(clk), .reset_n(reset_n), .req(req_rr), .gnt(gnt_rr),
        .gnt_id(id_rr), .gnt_valid(val_rr), .timeout(to_rr));

    req_arbiter_4 #(.ROUND_ROBIN(1'b0), .MAX_HOLD(4)) dut_t4 (
        .clk(clk), .reset_n(reset_n), .req(req_t4), .gnt(gnt_t4),
        .gnt_id(id_t4), .gnt_valid(val_t4), .timeout(to_t4));

    req_arbiter_4 #(.ROUND_ROBIN(1'b1), .MAX_HOLD(2)) dut_t2 (
        .clk(clk), .reset_n(reset_n), .req(req_t2), .gnt(gnt_t2),
        .gnt_id(id_t2), .gnt_valid(val_t2), .timeout(to_t2));

    req_arbiter_4 #(.ROUND_ROBIN(1'b1), .MAX_HOLD(3)) dut_t3 (
        .clk(clk), .reset_n(reset_n), .req(req_t3), .gnt(gnt_t3),
        .gnt_id(id_t3), .gnt_valid(val_t3), .timeout(to_t3));

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        tests_run++;
        if (obs_t4 !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %b expected %b", obs_t4, 8'b0000_00_0_0);
        end
        reset_n = 1'b1;
        req_t4  = 4'b0010;
        tick();
        tests_run++;
        if (obs_t4 !== 8'b0010_01_1_0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pre_grant: got %b expected %b", obs_t4, 8'b0010_01_1_0);
        end
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (obs_t4 !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async_drop: got %b expected %b", obs_t4, 8'b0000_00_0_0);
        end
        #2;
        reset_n = 1'b1;
        tick();
        tests_run++;
        if (obs_t4 !== 8'b0010_01_1_0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regrant: got %b expected %b", obs_t4, 8'b0010_01_1_0);
        end
        req_t4 = 4'b0000;
        tick();
        tests_run++;
        if (obs_t4 !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_idle: got %b expected %b", obs_t4, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_fixed_priority;
        req_fix = 4'b1111;
        tick();
        tests_run++;
        if (obs_fix !== 8'b1000_11_1_0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_first_3: got %b expected %b", obs_fix, 8'b1000_11_1_0);
        end
        tick();
        tests_run++;
        if (obs_fix !== 8'b1000_11_1_0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_hold_3: got %b expected %b", obs_fix, 8'b1000_11_1_0);
        end
        req_fix = 4'b0111;
        tick();
        tests_run++;
        if (obs_fix !== 8'b0100_10_1_0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_handoff_2: got %b expected %b", obs_fix, 8'b0100_10_1_0);
        end
        req_fix = 4'b1111;
        tick();
        tests_run++;
        if (obs_fix !== 8'b0100_10_1_0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_no_preempt: got %b expected %b", obs_fix, 8'b0100_10_1_0);
        end
        req_fix = 4'b0011;
        tick();
        tests_run++;
        if (obs_fix !== 8'b0010_01_1_0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_handoff_1: got %b expected %b", obs_fix, 8'b0010_01_1_0);
        end
        req_fix = 4'b0001;
        tick();
        tests_run++;
        if (obs_fix !== 8'b0001_00_1_0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_handoff_0: got %b expected %b", obs_fix, 8'b0001_00_1_0);
        end
        req_fix = 4'b0000;
        tick();
        tests_run++;
        if (obs_fix !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_idle: got %b expected %b", obs_fix, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] w;
        logic [7:0] exp;
        // A short tenure for requester 0 parks the pointer at 3.
        req_rr = 4'b0001;
        tick();
        tests_run++;
        if (obs_rr !== 8'b0001_00_1_0) begin
            tests_failed++;
            $display("[TB] FAIL rr_prime: got %b expected %b", obs_rr, 8'b0001_00_1_0);
        end
        req_rr = 4'b0000;
        tick();
        tests_run++;
        if (obs_rr !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL rr_prime_idle: got %b expected %b", obs_rr, 8'b0000_00_0_0);
        end
        req_rr = 4'b1111;
        tick();
        for (int i = 0; i < 6; i++) begin
            w   = 2'd3 - 2'(i % 4);
            exp = {4'b0001 << w, w, 1'b1, 1'b0};
            tests_run++;
            if (obs_rr !== exp) begin
                tests_failed++;
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", i, obs_rr, exp);
            end
            req_rr = 4'b1111;
            tick();
            tick();
            tests_run++;
            if (obs_rr !== exp) begin
                tests_failed++;
                $display("[TB] FAIL rr_hold_%0d: got %b expected %b", i, obs_rr, exp);
            end
            req_rr = 4'b1111 & ~(4'b0001 << w);
            tick();
        end
        req_rr = 4'b0000;
        tick();
        tests_run++;
        if (obs_rr !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL rr_idle: got %b expected %b", obs_rr, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_timeout;
        logic [1:0] owner;
        logic [7:0] exp;
        req_t4 = 4'b0101;
        tick();
        for (int s = 0; s < 4; s++) begin
            owner = (s % 2 == 0) ? 2'd2 : 2'd0;
            exp   = {4'b0001 << owner, owner, 1'b1, (s != 0)};
            tests_run++;
            if (obs_t4 !== exp) begin
                tests_failed++;
                $display("[TB] FAIL timeout_swap_%0d: got %b expected %b", s, obs_t4, exp);
            end
            exp = {4'b0001 << owner, owner, 1'b1, 1'b0};
            for (int c = 0; c < 3; c++) begin
                tick();
                tests_run++;
                if (obs_t4 !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout_hold_%0d_%0d: got %b expected %b", s, c, obs_t4, exp);
                end
            end
            tick();
        end
        tests_run++;
        if (obs_t4 !== 8'b0100_10_1_1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_last_swap: got %b expected %b", obs_t4, 8'b0100_10_1_1);
        end
        req_t4 = 4'b0000;
        tick();
        tests_run++;
        if (obs_t4 !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_idle: got %b expected %b", obs_t4, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_lone_timeout;
        req_t2 = 4'b1000;
        tick();
        tests_run++;
        if (obs_t2 !== 8'b1000_11_1_0) begin
            tests_failed++;
            $display("[TB] FAIL lone_grant: got %b expected %b", obs_t2, 8'b1000_11_1_0);
        end
        tick();
        tests_run++;
        if (obs_t2 !== 8'b1000_11_1_0) begin
            tests_failed++;
            $display("[TB] FAIL lone_hold: got %b expected %b", obs_t2, 8'b1000_11_1_0);
        end
        tick();
        tests_run++;
        if (obs_t2 !== 8'b0000_00_0_1) begin
            tests_failed++;
            $display("[TB] FAIL lone_timeout_idle: got %b expected %b", obs_t2, 8'b0000_00_0_1);
        end
        tick();
        tests_run++;
        if (obs_t2 !== 8'b1000_11_1_0) begin
            tests_failed++;
            $display("[TB] FAIL lone_regrant: got %b expected %b", obs_t2, 8'b1000_11_1_0);
        end
        req_t2 = 4'b0000;
        tick();
        tests_run++;
        if (obs_t2 !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL lone_idle: got %b expected %b", obs_t2, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_collision;
        req_t3 = 4'b0001;
        tick();
        tests_run++;
        if (obs_t3 !== 8'b0001_00_1_0) begin
            tests_failed++;
            $display("[TB] FAIL coll_grant: got %b expected %b", obs_t3, 8'b0001_00_1_0);
        end
        req_t3 = 4'b0011;
        tick();
        tick();
        tests_run++;
        if (obs_t3 !== 8'b0001_00_1_0) begin
            tests_failed++;
            $display("[TB] FAIL coll_pending_ignored: got %b expected %b", obs_t3, 8'b0001_00_1_0);
        end
        req_t3 = 4'b0010;
        tick();
        tests_run++;
        if (obs_t3 !== 8'b0010_01_1_0) begin
            tests_failed++;
            $display("[TB] FAIL coll_release_wins: got %b expected %b", obs_t3, 8'b0010_01_1_0);
        end
        req_t3 = 4'b0000;
        tick();
        tests_run++;
        if (obs_t3 !== 8'b0000_00_0_0) begin
            tests_failed++;
            $display("[TB] FAIL coll_idle: got %b expected %b", obs_t3, 8'b0000_00_0_0);
        end
    endtask

    // Scenario sequence.
    initial begin
        reset_n = 1'b0;
        req_fix = 4'b0000;
        req_rr  = 4'b0000;
        req_t4  = 4'b0000;
        req_t2  = 4'b0000;
        req_t3  = 4'b0000;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_lone_timeout();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
